// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble binary-to-packed-BCD converter: one shift per clock,
// start/busy/valid handshake, sticky overflow and leading-zero blanking mask.
module binary_to_bcd_seq #(
  parameter int INPUT_WIDTH    = 8,
  parameter int DECIMAL_DIGITS = 3
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset_n,
  input  logic                          i_Start,
  input  logic [INPUT_WIDTH-1:0]        i_Binary,
  output logic                          o_Busy,
  output logic                          o_Valid,
  output logic [DECIMAL_DIGITS*4-1:0]   o_BCD,
  output logic                          o_Overflow,
  output logic [DECIMAL_DIGITS-1:0]     o_Digit_Enable
);

  localparam int BW = DECIMAL_DIGITS * 4;
  localparam int CW = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
  localparam logic [CW-1:0]             CNT_LAST = CW'(INPUT_WIDTH - 1);
  localparam logic [DECIMAL_DIGITS-1:0] EN_RESET = DECIMAL_DIGITS'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                     state_q, state_d;
  logic [INPUT_WIDTH-1:0]     shift_q, shift_d;
  logic [BW-1:0]              scratch_q, scratch_d;
  logic                       carry_q, carry_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       valid_q, valid_d;
  logic [BW-1:0]              bcd_q, bcd_d;
  logic                       ovf_q, ovf_d;
  logic [DECIMAL_DIGITS-1:0]  en_q, en_d;

  logic [BW-1:0]              adjusted;
  logic [DECIMAL_DIGITS-1:0]  mask;

  // Per-digit add-3 correction and blanking mask; any carry out of the top
  // digit means higher (truncated) digits are nonzero, so every digit lights.
  generate
    for (genvar gi = 0; gi < DECIMAL_DIGITS; gi++) begin : g_digit
      assign adjusted[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                                   scratch_q[gi*4 +: 4] + 4'd3 : scratch_q[gi*4 +: 4];
      if (gi == 0) begin : g_ones
        assign mask[gi] = 1'b1;
      end else begin : g_upper
        assign mask[gi] = carry_q | (|scratch_q[BW-1:gi*4]);
      end
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    carry_d   = carry_q;
    count_d   = count_q;
    valid_d   = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    en_d      = en_q;
    case (state_q)
      IDLE: begin
        if (i_Start) begin
          shift_d   = i_Binary;
          scratch_d = '0;
          carry_d   = 1'b0;
          count_d   = CNT_LAST;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {adjusted[BW-2:0], shift_q[INPUT_WIDTH-1]};
        carry_d   = carry_q | adjusted[BW-1];
        shift_d   = shift_q << 1;
        if (count_q == '0) begin
          state_d = DONE;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      DONE: begin
        bcd_d   = scratch_q;
        ovf_d   = carry_q;
        en_d    = mask;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      en_q      <= EN_RESET;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      carry_q   <= carry_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      en_q      <= en_d;
    end
  end

  assign o_Busy         = (state_q != IDLE);
  assign o_Valid        = valid_q;
  assign o_BCD          = bcd_q;
  assign o_Overflow     = ovf_q;
  assign o_Digit_Enable = en_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Bench for binary_to_bcd_seq: four parameterisations checked against an
// arithmetic (divide/modulo) reference model with directed and random values.
module tb_binary_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // inst0: W=8 D=3, inst1: W=7 D=2, inst2: W=10 D=3, inst3: W=1 D=1
  logic st0 = 0, st1 = 0, st2 = 0, st3 = 0;
  logic [7:0]  bin0 = '0;
  logic [6:0]  bin1 = '0;
  logic [9:0]  bin2 = '0;
  logic [0:0]  bin3 = '0;
  logic        b0, b1, b2, b3, v0, v1, v2, v3, o0, o1, o2, o3;
  logic [11:0] bcd0, bcd2;
  logic [7:0]  bcd1;
  logic [3:0]  bcd3;
  logic [2:0]  en0, en2;
  logic [1:0]  en1;
  logic [0:0]  en3;

  binary_to_bcd_seq #(.INPUT_WIDTH(8), .DECIMAL_DIGITS(3)) u0 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(st0), .i_Binary(bin0),
    .o_Busy(b0), .o_Valid(v0), .o_BCD(bcd0), .o_Overflow(o0), .o_Digit_Enable(en0));
  binary_to_bcd_seq #(.INPUT_WIDTH(7), .DECIMAL_DIGITS(2)) u1 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(st1), .i_Binary(bin1),
    .o_Busy(b1), .o_Valid(v1), .o_BCD(bcd1), .o_Overflow(o1), .o_Digit_Enable(en1));
  binary_to_bcd_seq #(.INPUT_WIDTH(10), .DECIMAL_DIGITS(3)) u2 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(st2), .i_Binary(bin2),
    .o_Busy(b2), .o_Valid(v2), .o_BCD(bcd2), .o_Overflow(o2), .o_Digit_Enable(en2));
  binary_to_bcd_seq #(.INPUT_WIDTH(1), .DECIMAL_DIGITS(1)) u3 (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_Start(st3), .i_Binary(bin3),
    .o_Busy(b3), .o_Valid(v3), .o_BCD(bcd3), .o_Overflow(o3), .o_Digit_Enable(en3));

  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic        s_valid, s_busy, s_ovf;
  logic [11:0] s_bcd;
  logic [2:0]  s_en;

  always_comb begin
    s_valid = v0; s_busy = b0; s_bcd = bcd0; s_ovf = o0; s_en = en0;
    case (sel)
      1: begin s_valid = v1; s_busy = b1; s_bcd = {4'h0, bcd1}; s_ovf = o1; s_en = {1'b0, en1}; end
      2: begin s_valid = v2; s_busy = b2; s_bcd = bcd2; s_ovf = o2; s_en = en2; end
      3: begin s_valid = v3; s_busy = b3; s_bcd = {8'h0, bcd3}; s_ovf = o3; s_en = {2'b0, en3}; end
      default: ;
    endcase
  end

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int pow10(input int d);
    int r = 1;
    repeat (d) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] ref_bcd(input int v, input int d);
    logic [31:0] r = '0;
    int m = v % pow10(d);
    for (int k = 0; k < d; k++) r[k*4 +: 4] = 4'((m / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [31:0] ref_ovf(input int v, input int d);
    return (v >= pow10(d)) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] ref_mask(input int v, input int d);
    logic [31:0] r = '0;
    int m = v % pow10(d);
    for (int k = 0; k < d; k++)
      if (k == 0 || v >= pow10(d) || m >= pow10(k)) r[k] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input logic s, input int v);
    case (inst)
      0: begin st0 = s; bin0 = v[7:0]; end
      1: begin st1 = s; bin1 = v[6:0]; end
      2: begin st2 = s; bin2 = v[9:0]; end
      default: begin st3 = s; bin3 = v[0:0]; end
    endcase
  endtask

  // One conversion: pulse start, corrupt i_Binary while busy, check latency,
  // busy duration, result, and that o_Valid is a single-cycle pulse.
  task automatic convert(input int inst, input int v, input int w, input int d, input bit noise);
    int  edges, busy_cnt;
    bit  got;
    sel = inst;
    @(negedge clk); drive(inst, 1'b1, v);
    @(posedge clk); #1;
    drive(inst, 1'b0, int'($urandom));
    busy_cnt = int'(s_busy);
    edges = 0;
    got = 0;
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (noise && edges == 2) drive(inst, 1'b1, int'($urandom));
      if (noise && edges == 3) drive(inst, 1'b0, int'($urandom));
      if (s_valid) got = 1;
      else busy_cnt += int'(s_busy);
    end
    $display("conv inst=%0d in=%0d bcd=%0h ovf=%0b en=%0b lat=%0d", inst, v, s_bcd, s_ovf, s_en, edges);
    chk("latency", edges, w + 1);
    chk("busy_cycles", busy_cnt, w + 1);
    chk("bcd", {20'h0, s_bcd}, ref_bcd(v, d));
    chk("overflow", {31'h0, s_ovf}, ref_ovf(v, d));
    chk("mask", {29'h0, s_en}, ref_mask(v, d));
    @(posedge clk); #1;
    chk("valid_fall", {31'h0, s_valid}, 32'd0);
    chk("hold_bcd", {20'h0, s_bcd}, ref_bcd(v, d));
    if (noise) begin
      repeat (w + 3) begin
        @(posedge clk); #1;
        chk("no_queued_start", {31'h0, s_valid}, 32'd0);
      end
    end
  endtask

  initial begin
    int edges, first, second, v;

    repeat (3) @(posedge clk);
    #1;
    sel = 0;
    chk("rst_bcd", {20'h0, s_bcd}, 32'd0);
    chk("rst_ovf", {31'h0, s_ovf}, 32'd0);
    chk("rst_mask", {29'h0, s_en}, 32'd1);
    chk("rst_valid", {31'h0, s_valid}, 32'd0);
    chk("rst_busy", {31'h0, s_busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    convert(0, 255, 8, 3, 0);
    convert(0, 0, 8, 3, 0);
    convert(0, 7, 8, 3, 0);
    convert(0, 40, 8, 3, 0);
    convert(0, 123, 8, 3, 1);
    convert(0, 200, 8, 3, 0);
    for (int i = 0; i < 20; i++) convert(0, int'($urandom_range(255)), 8, 3, 0);

    convert(1, 127, 7, 2, 0);
    convert(1, 99, 7, 2, 0);
    for (int i = 0; i < 20; i++) convert(1, int'($urandom_range(127)), 7, 2, 0);

    convert(3, 0, 1, 1, 0);
    convert(3, 1, 1, 1, 0);
    convert(3, 1, 1, 1, 0);
    convert(3, 0, 1, 1, 0);

    // Start held high: one result every INPUT_WIDTH+2 cycles.
    sel = 0;
    @(negedge clk); drive(0, 1'b1, 200);
    edges = 0; first = -1; second = -1;
    while (second < 0 && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      if (s_valid) begin
        if (first < 0) first = edges;
        else second = edges;
      end
    end
    drive(0, 1'b0, 0);
    $display("held_start first=%0d second=%0d", first, second);
    chk("held_period", second - first, 32'd10);
    chk("held_bcd", {20'h0, s_bcd}, ref_bcd(200, 3));
    repeat (12) @(posedge clk);

    // Asynchronous reset four SHIFT edges into a conversion.
    @(negedge clk); drive(0, 1'b1, 200);
    @(posedge clk); #1; drive(0, 1'b0, 200);
    repeat (4) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    $display("abort bcd=%0h ovf=%0b en=%0b busy=%0b", s_bcd, s_ovf, s_en, s_busy);
    chk("abort_bcd", {20'h0, s_bcd}, 32'd0);
    chk("abort_ovf", {31'h0, s_ovf}, 32'd0);
    chk("abort_mask", {29'h0, s_en}, 32'd1);
    chk("abort_busy", {31'h0, s_busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      chk("abort_no_valid", {31'h0, s_valid}, 32'd0);
    end
    convert(0, 200, 8, 3, 0);

    // Exhaustive sweep of the 10-bit, 3-digit converter.
    for (int i = 0; i < 1024; i++) begin
      v = i;
      convert(2, v, 10, 3, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
